stk_seq: RTL and testbench

STK_SEQ -- requirements
Module: stk_seq

---
 rtl/stk_seq.sv | 183 ++++++++++++++++++
 tb/tb_stk_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/stk_seq.sv
// Stack micro-sequencer: expands PUSH/POP/CALL/RET into register-file, ALU,
// data-memory and PC control steps that override the normal decoder.
// Parameters: STK_LO (full SP), STK_HI (empty/reset SP).
// Ports: clk, rst_n (async, active-low), o/go (instruction word and valid),
//   abort (sync flush), spv (current SP value), busy (stall fetch),
//   ovr (override decoder), ra/rb/wad (regfile addresses), op (ALU op),
//   bim (B operand = 1), we/dmwe/dms/pcwe/pcs (write and select strobes),
//   done (final step pulse), fault (stack bound fault pulse).
// Optional macro STK_BOUND_EN: refuse PUSH/CALL at STK_LO and POP/RET at
//   STK_HI, pulsing fault instead of starting.
module stk_seq #(
    parameter logic [15:0] STK_LO = 16'h0080,
    parameter logic [15:0] STK_HI = 16'h0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] o,
    input  logic        go,
    input  logic        abort,
    input  logic [15:0] spv,
    output logic        busy,
    output logic        ovr,
    output logic [1:0]  ra,
    output logic [1:0]  rb,
    output logic [1:0]  wad,
    output logic [3:0]  op,
    output logic        bim,
    output logic        we,
    output logic        dmwe,
    output logic        dms,
    output logic        pcwe,
    output logic        pcs,
    output logic        done,
    output logic        fault
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DEC  = 3'd1,
        MEM  = 3'd2,
        JMP  = 3'd3,
        INC  = 3'd4
    } state_t;

    localparam logic [1:0] S_PUSH = 2'b00;
    localparam logic [1:0] S_POP  = 2'b01;
    localparam logic [1:0] S_CALL = 2'b10;
    localparam logic [1:0] S_RET  = 2'b11;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_THA = 4'b1110;
    localparam logic [3:0] OP_THB = 4'b1111;

    state_t     state;
    logic [1:0] sub;
    logic [1:0] spr;
    logic [1:0] dr;

    logic hit;
    logic viol;
    logic start;
    logic fin;

    // rst_n gates hit so every output sits at its idle value during reset
    assign hit = rst_n & go & ~abort & (state == IDLE)
               & (o[15:6] == 10'b0000000001);

`ifdef STK_BOUND_EN
    // o[4] clear means PUSH/CALL (grows the stack), set means POP/RET
    assign viol = o[4] ? (spv == STK_HI) : (spv == STK_LO);
`else
    logic unused_spv;
    assign unused_spv = ^spv;
    assign viol = 1'b0;
`endif

    assign start = hit & ~viol;
    assign fault = hit & viol;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sub   <= 2'b00;
            spr   <= 2'b00;
            dr    <= 2'b00;
        end else if (state != IDLE && abort) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sub   <= o[5:4];
                        spr   <= o[3:2];
                        dr    <= o[1:0];
                        state <= o[4] ? MEM : DEC;
                    end
                end
                DEC: state <= MEM;
                MEM: begin
                    unique case (sub)
                        S_PUSH:  state <= IDLE;
                        S_CALL:  state <= JMP;
                        default: state <= INC;
                    endcase
                end
                JMP:     state <= IDLE;
                INC:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign fin = (state == JMP) | (state == INC)
               | ((state == MEM) & (sub == S_PUSH));

    assign busy = start | ((state != IDLE) & ~fin);
    assign done = fin & ~abort;

    always_comb begin
        ovr  = 1'b0;
        ra   = 2'b00;
        rb   = 2'b00;
        wad  = 2'b00;
        op   = OP_THB;
        bim  = 1'b0;
        we   = 1'b0;
        dmwe = 1'b0;
        dms  = 1'b0;
        pcwe = 1'b0;
        pcs  = 1'b0;
        unique case (state)
            DEC: begin
                ovr = 1'b1;
                ra  = spr;
                wad = spr;
                op  = OP_SUB;
                bim = 1'b1;
                we  = 1'b1;
            end
            MEM: begin
                ovr = 1'b1;
                ra  = spr;
                op  = OP_THA;
                if (sub == S_PUSH || sub == S_CALL) begin
                    rb   = dr;
                    dmwe = 1'b1;
                    pcs  = (sub == S_CALL);
                end else begin
                    dms = 1'b1;
                    if (sub == S_RET) begin
                        pcwe = 1'b1;
                    end else begin
                        we  = 1'b1;
                        wad = dr;
                    end
                end
            end
            JMP: begin
                ovr  = 1'b1;
                rb   = dr;
                op   = OP_THB;
                pcwe = 1'b1;
            end
            INC: begin
                ovr = 1'b1;
                ra  = spr;
                wad = spr;
                op  = OP_ADD;
                bim = 1'b1;
                we  = 1'b1;
            end
            default: ;
        endcase
        // a flush kills every architectural write in the current step
        if (state != IDLE && abort) begin
            we   = 1'b0;
            dmwe = 1'b0;
            pcwe = 1'b0;
        end
    end

endmodule

// File: tb/tb_stk_seq.sv
// Directed-vector bench for stk_seq: each step drives inputs, lets the
// combinational outputs settle, and compares the full output bundle.
module tb_stk_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] o;
    logic        go;
    logic        abort;
    logic [15:0] spv;
    logic        busy, ovr, bim, we, dmwe, dms, pcwe, pcs, done, fault;
    logic [1:0]  ra, rb, wad;
    logic [3:0]  op;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stk_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .o     (o),
        .go    (go),
        .abort (abort),
        .spv   (spv),
        .busy  (busy),
        .ovr   (ovr),
        .ra    (ra),
        .rb    (rb),
        .wad   (wad),
        .op    (op),
        .bim   (bim),
        .we    (we),
        .dmwe  (dmwe),
        .dms   (dms),
        .pcwe  (pcwe),
        .pcs   (pcs),
        .done  (done),
        .fault (fault)
    );

    localparam logic [3:0] ADD = 4'b0000;
    localparam logic [3:0] SUB = 4'b0001;
    localparam logic [3:0] THA = 4'b1110;
    localparam logic [3:0] THB = 4'b1111;

    logic [19:0] obs;
    assign obs = {busy, ovr, ra, rb, wad, op, bim,
                  we, dmwe, dms, pcwe, pcs, done, fault};

    // field order: busy ovr ra rb wad op bim we dmwe dms pcwe pcs done fault
    function automatic logic [19:0] pk(
        input logic b, input logic v,
        input logic [1:0] a, input logic [1:0] bb, input logic [1:0] w,
        input logic [3:0] p, input logic im, input logic e,
        input logic dw, input logic ds, input logic pw, input logic ps,
        input logic dn, input logic f);
        return {b, v, a, bb, w, p, im, e, dw, ds, pw, ps, dn, f};
    endfunction

    logic [19:0] idle_v;
    assign idle_v = pk(0,0,2'd0,2'd0,2'd0,THB,0,0,0,0,0,0,0,0);

    task automatic chk(input string tag, input logic [19:0] got,
                       input logic [19:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %05h want %05h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic g, input logic [15:0] w, input logic ab);
        go    = g;
        o     = w;
        abort = ab;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        o     = 16'h0000;
        go    = 1'b0;
        abort = 1'b0;
        spv   = 16'h00F0;
        #12;
        chk("reset", obs, idle_v);
        cyc();
        rst_n = 1'b1;
        cyc();

        // PUSH r1, SP=r3
        drv(1, 16'h004D, 0);
        chk("push_start", obs, pk(1,0,0,0,0,THB,0,0,0,0,0,0,0,0));
        cyc(); drv(0, 16'h0000, 0);
        chk("push_dec", obs, pk(1,1,3,0,3,SUB,1,1,0,0,0,0,0,0));
        cyc(); drv(0, 16'h0000, 0);
        chk("push_mem", obs, pk(0,1,3,1,0,THA,0,0,1,0,0,0,1,0));
        cyc(); drv(0, 16'h0000, 0);
        chk("push_idle", obs, idle_v);

        // POP r2, SP=r3
        drv(1, 16'h005E, 0);
        chk("pop_start", obs, pk(1,0,0,0,0,THB,0,0,0,0,0,0,0,0));
        cyc(); drv(0, 16'h0000, 0);
        chk("pop_mem", obs, pk(1,1,3,0,2,THA,0,1,0,1,0,0,0,0));
        cyc(); drv(0, 16'h0000, 0);
        chk("pop_inc", obs, pk(0,1,3,0,3,ADD,1,1,0,0,0,0,1,0));
        cyc(); drv(0, 16'h0000, 0);

        // CALL r0, then RET accepted in the cycle right after done
        drv(1, 16'h006C, 0);
        chk("call_start", obs, pk(1,0,0,0,0,THB,0,0,0,0,0,0,0,0));
        cyc(); drv(0, 16'h0000, 0);
        chk("call_dec", obs, pk(1,1,3,0,3,SUB,1,1,0,0,0,0,0,0));
        cyc(); drv(0, 16'h0000, 0);
        chk("call_mem", obs, pk(1,1,3,0,0,THA,0,0,1,0,0,1,0,0));
        cyc(); drv(0, 16'h0000, 0);
        chk("call_jmp", obs, pk(0,1,0,0,0,THB,0,0,0,0,1,0,1,0));
        cyc(); drv(1, 16'h007C, 0);
        chk("ret_start", obs, pk(1,0,0,0,0,THB,0,0,0,0,0,0,0,0));
        cyc(); drv(0, 16'h0000, 0);
        chk("ret_mem", obs, pk(1,1,3,0,0,THA,0,0,0,1,1,0,0,0));
        cyc(); drv(0, 16'h0000, 0);
        chk("ret_inc", obs, pk(0,1,3,0,3,ADD,1,1,0,0,0,0,1,0));
        cyc(); drv(0, 16'h0000, 0);
        chk("ret_idle", obs, idle_v);

        // go while busy is ignored
        drv(1, 16'h004D, 0);
        cyc(); drv(1, 16'h005E, 0);
        chk("busy_go_dec", obs, pk(1,1,3,0,3,SUB,1,1,0,0,0,0,0,0));
        cyc(); drv(0, 16'h0000, 0);
        chk("busy_go_mem", obs, pk(0,1,3,1,0,THA,0,0,1,0,0,0,1,0));
        cyc(); drv(0, 16'h0000, 0);
        chk("busy_go_idle", obs, idle_v);

        // abort during MEM of PUSH
        drv(1, 16'h004D, 0);
        cyc(); drv(0, 16'h0000, 0);
        cyc(); drv(0, 16'h0000, 1);
        chk("abort_mem", obs, pk(0,1,3,1,0,THA,0,0,0,0,0,0,0,0));
        cyc(); drv(0, 16'h0000, 0);
        chk("abort_idle", obs, idle_v);

        // reset during DEC of CALL, then start right after release
        drv(1, 16'h006C, 0);
        cyc(); drv(0, 16'h0000, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_in_dec", obs, idle_v);
        cyc();
        rst_n = 1'b1;
        drv(1, 16'h004D, 0);
        cyc(); drv(0, 16'h0000, 0);
        chk("post_rst_dec", obs, pk(1,1,3,0,3,SUB,1,1,0,0,0,0,0,0));
        cyc(); drv(0, 16'h0000, 0);
        cyc(); drv(0, 16'h0000, 0);

        // non-stack instruction
        drv(1, 16'h0100, 0);
        chk("eva_nostart", obs, idle_v);
        cyc(); drv(0, 16'h0000, 0);
        chk("eva_idle", obs, idle_v);

        // bound checks at the stack limits
        spv = 16'h0080;
        drv(1, 16'h004D, 0);
`ifdef STK_BOUND_EN
        chk("bound_push", obs, pk(0,0,0,0,0,THB,0,0,0,0,0,0,0,1));
        cyc(); drv(0, 16'h0000, 0);
        chk("bound_push_nx", obs, idle_v);
        spv = 16'h0100;
        drv(1, 16'h005E, 0);
        chk("bound_pop", obs, pk(0,0,0,0,0,THB,0,0,0,0,0,0,0,1));
        cyc(); drv(0, 16'h0000, 0);
        chk("bound_pop_nx", obs, idle_v);
`else
        chk("nobound_push", obs, pk(1,0,0,0,0,THB,0,0,0,0,0,0,0,0));
        cyc(); drv(0, 16'h0000, 0);
        chk("nobound_dec", obs, pk(1,1,3,0,3,SUB,1,1,0,0,0,0,0,0));
        cyc(); drv(0, 16'h0000, 0);
        cyc(); drv(0, 16'h0000, 0);
        spv = 16'h0100;
        drv(1, 16'h005E, 0);
        cyc(); drv(0, 16'h0000, 0);
        chk("nobound_pop", obs, pk(1,1,3,0,2,THA,0,1,0,1,0,0,0,0));
        cyc(); drv(0, 16'h0000, 0);
        cyc(); drv(0, 16'h0000, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
